// File: rtl/edge_evt_pkg.sv
// rtl/edge_evt_pkg.sv - shared types and slot mapping for the edge event arbiter
package edge_evt_pkg;

  typedef enum logic {POL_NEG = 1'b0, POL_POS = 1'b1} edge_pol_t;

  // Rising edges occupy the even slot of a channel pair, falling edges the odd one.
  localparam int SLOT_POS_OFS = 0;
  localparam int SLOT_NEG_OFS = 1;

  function automatic int slot_of(int ch, edge_pol_t pol);
    return 2 * ch + ((pol == POL_POS) ? SLOT_POS_OFS : SLOT_NEG_OFS);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin search starting at a pointer
module rr_arbiter #(
  parameter int N_REQ = 8,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [2*N_REQ-1:0] dbl_req;
  int                 found;

  // Duplicate the request vector so the wrap-around search is a plain lowest-set-bit scan
  // over bits at or above ptr; the lowest match is the first slot at/after ptr.
  always_comb begin
    dbl_req = {req, req};
    found   = -1;
    for (int i = 2 * N_REQ - 1; i >= 0; i--) begin
      if (dbl_req[i] && (i >= int'(ptr))) found = i;
    end
    gnt_vld = (found >= 0);
    if (found >= N_REQ) gnt_idx = IDX_W'(found - N_REQ);
    else if (found >= 0) gnt_idx = IDX_W'(found);
    else gnt_idx = '0;
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - serialises per-channel edge pulses onto one event stream
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] ev_pos,
  input  logic [N_CH-1:0] ev_neg,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic            out_pol,
  output logic [N_CH-1:0] overrun,
  input  logic [N_CH-1:0] clr_overrun
);

  localparam int N_SLOT = 2 * N_CH;
  localparam int S_W    = CH_W + 1;

  logic [N_SLOT-1:0] pend;
  logic [N_SLOT-1:0] set_vec;
  logic [N_SLOT-1:0] gnt_mask;
  logic [N_SLOT-1:0] lost;
  logic [N_CH-1:0]   ovr_set;
  logic [S_W-1:0]    rr_ptr;
  logic              gnt_vld;
  logic [S_W-1:0]    gnt_idx;
  logic              load;

  rr_arbiter #(.N_REQ(N_SLOT), .IDX_W(S_W)) u_rr (
    .req     (pend),
    .ptr     (rr_ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  // Map pulses to slots, work out which slot leaves this cycle and which pulses are lost.
  always_comb begin
    set_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      set_vec[S_W'(slot_of(i, POL_POS))] = ev_pos[i];
      set_vec[S_W'(slot_of(i, POL_NEG))] = ev_neg[i];
    end
    load     = !out_valid || out_ready;
    gnt_mask = (load && gnt_vld) ? (N_SLOT'(1) << gnt_idx) : '0;
    lost     = set_vec & pend & ~gnt_mask;
    for (int i = 0; i < N_CH; i++) begin
      ovr_set[i] = lost[2*i] | lost[2*i+1];
    end
  end

  // Pending flags, output register, round-robin pointer and sticky overrun bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_pol   <= 1'b0;
      overrun   <= '0;
      rr_ptr    <= '0;
    end else begin
      pend    <= (pend & ~gnt_mask) | set_vec;
      overrun <= (overrun & ~clr_overrun) | ovr_set;
      if (load) begin
        if (gnt_vld) begin
          out_valid <= 1'b1;
          out_ch    <= gnt_idx[S_W-1:1];
          out_pol   <= ~gnt_idx[0];
          rr_ptr    <= (gnt_idx == S_W'(N_SLOT - 1)) ? '0 : gnt_idx + 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - self-checking bench for edge_event_arbiter
module tb_edge_event_arbiter;

  localparam int N_CH = 4;
  localparam int NS   = 2 * N_CH;

  logic            clk;
  logic            rst;
  logic [N_CH-1:0] ev_pos;
  logic [N_CH-1:0] ev_neg;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_ch;
  logic            out_pol;
  logic [N_CH-1:0] overrun;
  logic [N_CH-1:0] clr_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  edge_event_arbiter #(.N_CH(N_CH)) dut (
    .clk         (clk),
    .rst         (rst),
    .ev_pos      (ev_pos),
    .ev_neg      (ev_neg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_pol     (out_pol),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic [3:0] pos;
    logic [3:0] neg;
    logic       ready;
    logic [3:0] clr;
    logic       ev;
    logic [1:0] ch;
    logic       pol;
    logic [3:0] ovr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] p, input logic [3:0] n, input logic rdy,
                     input logic [3:0] c, input logic e, input logic [1:0] ch, input logic pl,
                     input logic [3:0] o);
    vec_t v;
    v.rst = r; v.pos = p; v.neg = n; v.ready = rdy; v.clr = c;
    v.ev = e; v.ch = ch; v.pol = pl; v.ovr = o;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot = 2*ch + neg, first pending slot found scanning from ptr modulo NS.
  bit       m_pend[NS];
  bit       m_valid;
  int       m_ch;
  bit       m_pol;
  int       m_ptr;
  bit [3:0] m_ovr;

  task automatic model_step(input bit r, input bit [3:0] p, input bit [3:0] n, input bit rdy,
                            input bit [3:0] c);
    int  granted;
    bit  pulse;
    bit  old_pend[NS];
    bit [3:0] ovr_set;
    if (r) begin
      foreach (m_pend[s]) m_pend[s] = 0;
      m_valid = 0; m_ch = 0; m_pol = 0; m_ptr = 0; m_ovr = 0;
      return;
    end
    old_pend = m_pend;
    granted  = -1;
    if (!m_valid || rdy) begin
      for (int k = 0; k < NS; k++) begin
        int s;
        s = (m_ptr + k) % NS;
        if (granted < 0 && old_pend[s]) granted = s;
      end
      if (granted >= 0) begin
        m_valid = 1;
        m_ch    = granted / 2;
        m_pol   = (granted % 2 == 0);
        m_ptr   = (granted + 1) % NS;
      end else begin
        m_valid = 0;
      end
    end
    ovr_set = 0;
    for (int s = 0; s < NS; s++) begin
      pulse = (s % 2 == 0) ? p[s/2] : n[s/2];
      if (pulse && old_pend[s] && s != granted) ovr_set[s/2] = 1;
      m_pend[s] = (old_pend[s] && s != granted) || pulse;
    end
    m_ovr = (m_ovr & ~c) | ovr_set;
  endtask

  task automatic drive(input logic r, input logic [3:0] p, input logic [3:0] n, input logic rdy,
                       input logic [3:0] c);
    rst = r; ev_pos = p; ev_neg = n; out_ready = rdy; clr_overrun = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ev_pos = '0; ev_neg = '0; out_ready = 1'b1; clr_overrun = '0;

    // reset holds everything low even with pulses present, then first grant searches from slot 0
    add(1, 4'hF, 4'hF, 1, 0, 0, 0, 0, 0);
    add(1, 4'hF, 4'hF, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 4'b1000, 4'b0001, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 3, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // single event, one cycle of valid
    add(0, 4'b0100, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 2, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // fairness from a fresh pointer: eight back-to-back events
    add(1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 4'hF, 4'hF, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 0, 1, 2'(i / 2), (i % 2 == 0), 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // stall hold, one extra pending, then an overrun on ch1
    add(0, 4'b0010, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 1, 1, 1, 0);
    add(0, 4'b0010, 0, 0, 0, 1, 1, 1, 0);
    add(0, 4'b0010, 0, 0, 0, 1, 1, 1, 4'b0010);
    add(0, 0, 0, 1, 0, 1, 1, 1, 4'b0010);
    add(0, 0, 0, 1, 0, 0, 0, 0, 4'b0010);
    add(0, 0, 0, 1, 4'b0010, 0, 0, 0, 0);
    // overrun set beats a concurrent clear on ch3
    add(0, 4'b1000, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 3, 1, 0);
    add(0, 4'b1000, 0, 0, 0, 1, 3, 1, 0);
    add(0, 4'b1000, 0, 0, 0, 1, 3, 1, 4'b1000);
    add(0, 4'b1000, 0, 0, 4'b1000, 1, 3, 1, 4'b1000);
    add(0, 0, 0, 0, 4'b1000, 1, 3, 1, 0);
    add(0, 0, 0, 1, 0, 1, 3, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // reset mid-stream drops presented and pending events
    add(0, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].pos, tbl[i].neg, tbl[i].ready, tbl[i].clr);
      chk($sformatf("vec%0d_valid", i), int'(out_valid), int'(tbl[i].ev));
      if (tbl[i].ev || tbl[i].rst) begin
        chk($sformatf("vec%0d_ch", i), int'(out_ch), int'(tbl[i].ch));
        chk($sformatf("vec%0d_pol", i), int'(out_pol), int'(tbl[i].pol));
      end
      chk($sformatf("vec%0d_overrun", i), int'(overrun), int'(tbl[i].ovr));
    end

    // randomized traffic against the reference model
    model_step(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit       r;
      bit [3:0] p, n, c;
      bit       rdy;
      r   = ($urandom_range(0, 299) == 0);
      p   = 4'($urandom & $urandom & $urandom);
      n   = 4'($urandom & $urandom & $urandom);
      rdy = ($urandom_range(0, 9) < 7);
      c   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      model_step(r, p, n, rdy, c);
      drive(r, p, n, rdy, c);
      chk("rnd_valid", int'(out_valid), int'(m_valid));
      if (m_valid) begin
        chk("rnd_ch", int'(out_ch), m_ch);
        chk("rnd_pol", int'(out_pol), int'(m_pol));
      end
      chk("rnd_overrun", int'(overrun), int'(m_ovr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
